zcu216_mmcm_drp_reconfig: RTL



---
 rtl/zcu216_mmcm_drp_reconfig.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/zcu216_mmcm_drp_reconfig.sv
// Run-time MMCME4 reprogrammer: holds the MMCM in reset, does one DRP read-modify-write
// per streamed entry, then releases reset and waits for a synchronized LOCKED.
module zcu216_mmcm_drp_reconfig #(
  parameter int RST_HOLD     = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic [15:0] cfg_mask,
  input  logic        cfg_last,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);
  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam int DW = $clog2(DRDY_TIMEOUT) + 1;
  localparam int LW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RST_HOLD  = 4'd1;
  localparam logic [3:0] S_RD_REQ    = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_WR_REQ    = 4'd4;
  localparam logic [3:0] S_WR_WAIT   = 4'd5;
  localparam logic [3:0] S_AWAIT     = 4'd6;
  localparam logic [3:0] S_LOCK_WAIT = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  logic [3:0]    state;
  logic [15:0]   data_q, mask_q;
  logic          last_q;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] drdy_cnt;
  logic [LW-1:0] lock_cnt;
  logic          locked_meta, locked_sync;
  logic          accept;

  // Gated by rst_n so the handshake is closed while reset is held.
  assign cfg_ready = rst_n && (state == S_IDLE || state == S_AWAIT);
  assign accept    = cfg_valid && cfg_ready;
  assign drp_den   = (state == S_RD_REQ) || (state == S_WR_REQ);
  assign drp_dwe   = (state == S_WR_REQ);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      locked_meta <= mmcm_locked;
      locked_sync <= locked_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drp_daddr <= '0;
      drp_di    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      last_q    <= 1'b0;
      hold_cnt  <= '0;
      drdy_cnt  <= '0;
      lock_cnt  <= '0;
      mmcm_rst  <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      if (accept) begin
        drp_daddr <= cfg_addr;
        data_q    <= cfg_data;
        mask_q    <= cfg_mask;
        last_q    <= cfg_last;
      end
      case (state)
        S_IDLE: if (accept) begin
          err      <= 1'b0;
          err_code <= 2'd0;
          mmcm_rst <= 1'b1;
          hold_cnt <= '0;
          state    <= S_RST_HOLD;
        end
        S_RST_HOLD:
          if (hold_cnt == HW'(RST_HOLD - 1)) state <= S_RD_REQ;
          else hold_cnt <= hold_cnt + 1'b1;
        S_RD_REQ: begin
          drdy_cnt <= '0;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT:
          if (drp_drdy) begin
            drp_di <= (drp_do & mask_q) | (data_q & ~mask_q);
            state  <= S_WR_REQ;
          end else if (drdy_cnt == DW'(DRDY_TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            mmcm_rst <= 1'b0;
            state    <= S_IDLE;
          end else drdy_cnt <= drdy_cnt + 1'b1;
        S_WR_REQ: begin
          drdy_cnt <= '0;
          state    <= S_WR_WAIT;
        end
        S_WR_WAIT:
          if (drp_drdy) begin
            if (last_q) begin
              mmcm_rst <= 1'b0;
              lock_cnt <= '0;
              state    <= S_LOCK_WAIT;
            end else state <= S_AWAIT;
          end else if (drdy_cnt == DW'(DRDY_TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_code <= 2'd1;
            mmcm_rst <= 1'b0;
            state    <= S_IDLE;
          end else drdy_cnt <= drdy_cnt + 1'b1;
        S_AWAIT: if (accept) state <= S_RD_REQ;
        // First 4 cycles skip LOCKED: the synchronizer may still show the pre-release value.
        S_LOCK_WAIT:
          if (lock_cnt >= LW'(4) && locked_sync) state <= S_DONE;
          else if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
            err      <= 1'b1;
            err_code <= 2'd2;
            state    <= S_IDLE;
          end else lock_cnt <= lock_cnt + 1'b1;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
